// File: rtl/asym_ram_pkg.sv
// Shared definitions for the asymmetric true-dual-port RAM controller:
// write-mode encodings, controller state type and a constant log2 helper.
package asym_ram_pkg;

  // Same-port read-during-write behaviour
  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Controller state: clear sweep, then normal port service
  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/asym_ram_rd_pipe.sv
// Per-port read pipeline: registers the access attributes next to the
// memory's read register, applies the same-port write mode, optionally adds
// an output register, and produces the valid pulse.
module asym_ram_rd_pipe
  import asym_ram_pkg::*;
#(
  parameter  int DW         = 8,
  parameter  int LANES      = 1,
  parameter  int WRITE_MODE = WM_READ_FIRST,
  parameter  int OUT_REG    = 1,
  localparam int LANE_W     = (LANES > 1) ? clog2(LANES) : 1,
  localparam int WW         = DW * LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [DW-1:0]     din_i,
  input  logic [WW-1:0]     rd_word_i,
  output logic [DW-1:0]     dout_o,
  output logic              vld_o
);

  logic              en_q;
  logic              we_q;
  logic [LANE_W-1:0] lane_q;
  logic [DW-1:0]     din_q;
  logic [DW-1:0]     lane_data;
  logic [DW-1:0]     s1_data;
  logic              s1_vld;
  logic [DW-1:0]     dout_q;
  logic              vld_q;

  // Capture access attributes on the same edge the memory word is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      lane_q <= '0;
      din_q  <= '0;
    end else begin
      en_q <= en_i;
      if (en_i) begin
        we_q   <= we_i;
        lane_q <= lane_i;
        din_q  <= din_i;
      end
    end
  end

  // Lane extraction and write-mode selection for the first-stage result
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    lane_data = rd_word_i[DW-1:0];
    if (LANES > 1) lane_data = rd_word_i[int'(lane_q)*DW +: DW];
    s1_data = lane_data;
    if (we_q && (WRITE_MODE == WM_WRITE_FIRST)) s1_data = din_q;
    s1_vld = en_q && !(we_q && (WRITE_MODE == WM_NO_CHANGE));
  end

  // Output register: holds the last delivered value between valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= s1_vld;
      if (s1_vld) dout_q <= s1_data;
    end
  end

  // Without the output register the first-stage result is presented directly
  assign vld_o  = (OUT_REG != 0) ? vld_q  : s1_vld;
  assign dout_o = (OUT_REG != 0) ? dout_q : (s1_vld ? s1_data : dout_q);

endmodule

// File: rtl/asym_tdp_ram_ctrl.sv
// Single-clock true-dual-port RAM with a narrow port A and a wide port B
// sharing one B_DEPTH x B_WIDTH array, with a post-reset clear sweep and a
// registered same-word collision flag.
module asym_tdp_ram_ctrl
  import asym_ram_pkg::*;
#(
  parameter  int A_WIDTH    = 8,
  parameter  int RATIO      = 2,
  parameter  int A_DEPTH    = 1024,
  parameter  int WRITE_MODE = WM_READ_FIRST,
  parameter  int OUT_REG    = 1,
  parameter  int INIT_CLEAR = 1,
  localparam int B_WIDTH    = A_WIDTH * RATIO,
  localparam int B_DEPTH    = A_DEPTH / RATIO,
  localparam int A_AW       = clog2(A_DEPTH),
  localparam int B_AW       = clog2(B_DEPTH),
  localparam int R_LOG      = clog2(RATIO),
  localparam int LANE_W     = (RATIO > 1) ? R_LOG : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               init_busy,
  input  logic               enA,
  input  logic               weA,
  input  logic [A_AW-1:0]    addrA,
  input  logic [A_WIDTH-1:0] dinA,
  output logic [A_WIDTH-1:0] doutA,
  output logic               doutA_vld,
  input  logic               enB,
  input  logic               weB,
  input  logic [B_AW-1:0]    addrB,
  input  logic [B_WIDTH-1:0] dinB,
  output logic [B_WIDTH-1:0] doutB,
  output logic               doutB_vld,
  output logic               collision
);

  state_e             state_q, state_d;
  logic [B_AW-1:0]    clr_addr_q, clr_addr_d;
  logic               ready;
  logic [A_AW-1:0]    addr_a_shr;
  logic [B_AW-1:0]    word_a;
  logic [LANE_W-1:0]  lane_a;
  logic               acc_a, acc_b, wr_a, wr_b;
  logic               coll_q;
  logic [B_WIDTH-1:0] mem [B_DEPTH];
  logic [B_WIDTH-1:0] rd_a_q, rd_b_q;

  // Port A address split into wide-word index and little-endian lane
  assign addr_a_shr = addrA >> R_LOG;
  assign word_a     = addr_a_shr[B_AW-1:0];
  if (RATIO > 1) begin : g_lane
    assign lane_a = addrA[R_LOG-1:0];
  end else begin : g_no_lane
    assign lane_a = '0;
  end

  assign ready     = (state_q == ST_READY);
  assign init_busy = (state_q == ST_INIT);
  assign acc_a     = ready && enA;
  assign acc_b     = ready && enB;
  assign wr_a      = acc_a && weA;
  assign wr_b      = acc_b && weB;

  // State and sweep-address register; reset restarts the sweep at word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Sweep one wide word per cycle; the all-ones address is the last word
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_INIT: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  // Shared array: sweep or port writes, plus both ports' synchronous reads
  always_ff @(posedge clk) begin
    // NOTE: the array and its read registers carry no reset so the tools can map them onto block RAM.
    if (state_q == ST_INIT) begin
      mem[clr_addr_q] <= '0;
    end else begin
      // Port A's lane write comes last so it wins on a same-word double write
      if (wr_b) mem[addrB] <= dinB;
      if (wr_a) mem[word_a][int'(lane_a)*A_WIDTH +: A_WIDTH] <= dinA;
    end
    // NOTE: non-blocking assignment makes these reads see the word as it was before this edge's writes.
    if (acc_a) rd_a_q <= mem[word_a];
    if (acc_b) rd_b_q <= mem[addrB];
  end

  // Same-word access with at least one write, flagged one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= acc_a && acc_b && (word_a == addrB) && (weA || weB);
  end

  assign collision = coll_q;

  asym_ram_rd_pipe #(
    .DW         (A_WIDTH),
    .LANES      (RATIO),
    .WRITE_MODE (WRITE_MODE),
    .OUT_REG    (OUT_REG)
  ) u_pipe_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (acc_a),
    .we_i      (weA),
    .lane_i    (lane_a),
    .din_i     (dinA),
    .rd_word_i (rd_a_q),
    .dout_o    (doutA),
    .vld_o     (doutA_vld)
  );

  asym_ram_rd_pipe #(
    .DW         (B_WIDTH),
    .LANES      (1),
    .WRITE_MODE (WRITE_MODE),
    .OUT_REG    (OUT_REG)
  ) u_pipe_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (acc_b),
    .we_i      (weB),
    .lane_i    (1'b0),
    .din_i     (dinB),
    .rd_word_i (rd_b_q),
    .dout_o    (doutB),
    .vld_o     (doutB_vld)
  );

endmodule

// File: tb/tb_asym_tdp_ram_ctrl.sv
// Bench for asym_tdp_ram_ctrl: three instances share stimulus and differ in
// write mode (0/1/2) and output register (1/1/0). A byte-addressed model of
// the array predicts every read result and its cycle; a negedge monitor pops
// and compares whenever the predicted cycle arrives.
module tb_asym_tdp_ram_ctrl;

  localparam int NI = 3;
  localparam int AD = 1024;
  localparam int BD = 512;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enA = 1'b0, weA = 1'b0, enB = 1'b0, weB = 1'b0;
  logic [9:0]    addrA = '0;
  logic [8:0]    addrB = '0;
  logic [7:0]    dinA = '0;
  logic [15:0]   dinB = '0;

  logic [NI-1:0] busy, vldA, vldB, coll;
  logic [7:0]    doutA [NI];
  logic [15:0]   doutB [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    asym_tdp_ram_ctrl #(
      .A_WIDTH    (8),
      .RATIO      (2),
      .A_DEPTH    (AD),
      .WRITE_MODE (g),
      .OUT_REG    ((g == 2) ? 0 : 1),
      .INIT_CLEAR (1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (busy[g]),
      .enA       (enA),
      .weA       (weA),
      .addrA     (addrA),
      .dinA      (dinA),
      .doutA     (doutA[g]),
      .doutA_vld (vldA[g]),
      .enB       (enB),
      .weB       (weB),
      .addrB     (addrB),
      .dinB      (dinB),
      .doutB     (doutB[g]),
      .doutB_vld (vldB[g]),
      .collision (coll[g])
    );
  end

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          mon_on = 1'b0;
  bit          model_on = 1'b0;
  logic [7:0]  mdl [AD];
  exp_t        qa [NI][$];
  exp_t        qb [NI][$];
  int          coll_due [$];
  logic [7:0]  last_a [NI];
  logic [15:0] last_b [NI];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the model predicts results from old contents, then applies writes
  task automatic drive(input logic ea, input logic wa, input logic [9:0] aa, input logic [7:0] da,
                       input logic eb, input logic wb, input logic [8:0] ab, input logic [15:0] db);
    exp_t        e;
    logic [7:0]  old_a;
    logic [15:0] old_b;
    int          lat;
    @(negedge clk);
    enA = ea; weA = wa; addrA = aa; dinA = da;
    enB = eb; weB = wb; addrB = ab; dinB = db;
    if (model_on) begin
      old_a = mdl[aa];
      old_b = {mdl[{ab, 1'b1}], mdl[{ab, 1'b0}]};
      for (int m = 0; m < NI; m++) begin
        lat = (m == 2) ? 1 : 2;
        if (ea && !(wa && m == 2)) begin
          e.data = {8'h00, (wa && m == 1) ? da : old_a};
          e.due  = cyc + lat;
          qa[m].push_back(e);
        end
        if (eb && !(wb && m == 2)) begin
          e.data = (wb && m == 1) ? db : old_b;
          e.due  = cyc + lat;
          qb[m].push_back(e);
        end
      end
      if (ea && eb && (aa >> 1) == 10'(ab) && (wa || wb)) coll_due.push_back(cyc + 1);
      if (eb && wb) begin
        mdl[{ab, 1'b0}] = db[7:0];
        mdl[{ab, 1'b1}] = db[15:8];
      end
      if (ea && wa) mdl[aa] = da;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Monitor: compare results in the predicted cycle, check silence and hold otherwise
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ec;
    if (mon_on) begin
      for (int m = 0; m < NI; m++) begin
        if (qa[m].size() > 0 && qa[m][0].due == cyc) begin
          e = qa[m].pop_front();
          check($sformatf("doutA_vld[%0d]", m), 32'(vldA[m]), 32'd1);
          check($sformatf("doutA[%0d]", m), 32'(doutA[m]), 32'(e.data[7:0]));
          last_a[m] <= e.data[7:0];
        end else if (vldA[m]) begin
          check($sformatf("unexpected doutA_vld[%0d]", m), 32'(vldA[m]), 32'd0);
        end else begin
          check($sformatf("doutA hold[%0d]", m), 32'(doutA[m]), 32'(last_a[m]));
        end
        if (qb[m].size() > 0 && qb[m][0].due == cyc) begin
          e = qb[m].pop_front();
          check($sformatf("doutB_vld[%0d]", m), 32'(vldB[m]), 32'd1);
          check($sformatf("doutB[%0d]", m), 32'(doutB[m]), 32'(e.data));
          last_b[m] <= e.data;
        end else if (vldB[m]) begin
          check($sformatf("unexpected doutB_vld[%0d]", m), 32'(vldB[m]), 32'd0);
        end else begin
          check($sformatf("doutB hold[%0d]", m), 32'(doutB[m]), 32'(last_b[m]));
        end
      end
      ec = (coll_due.size() > 0 && coll_due[0] == cyc);
      if (ec) void'(coll_due.pop_front());
      for (int m = 0; m < NI; m++) begin
        if (ec || coll[m]) check($sformatf("collision[%0d]", m), 32'(coll[m]), 32'(ec));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int m = 0; m < NI; m++) begin
      check($sformatf("%s init_busy[%0d]", tag, m), 32'(busy[m]), 32'd1);
      check($sformatf("%s doutA[%0d]", tag, m), 32'(doutA[m]), 32'd0);
      check($sformatf("%s doutB[%0d]", tag, m), 32'(doutB[m]), 32'd0);
      check($sformatf("%s vld[%0d]", tag, m), 32'({vldA[m], vldB[m]}), 32'd0);
      check($sformatf("%s collision[%0d]", tag, m), 32'(coll[m]), 32'd0);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n_busy;
    for (int m = 0; m < NI; m++) begin
      last_a[m] = '0;
      last_b[m] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // First sweep, interrupted by an asynchronous reset around sweep cycle 100
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-sweep reset");
    @(negedge clk);

    // Restarted sweep: count busy cycles, poke both ports (writes to already
    // cleared words 0 and 1) during a window well inside the sweep
    rst_n  = 1'b1;
    n_busy = 0;
    while (busy[0] && n_busy < 2000) begin
      n_busy++;
      enA = (n_busy >= 300 && n_busy < 400);
      weA = enA; addrA = 10'd0; dinA = 8'hFF;
      enB = enA; weB = enA; addrB = 9'd1; dinB = 16'hFFFF;
      @(negedge clk);
    end
    enA = 0; weA = 0; enB = 0; weB = 0;
    check("init_busy length", 32'(n_busy), 32'd512);
    check("init_busy[1] after sweep", 32'(busy[1]), 32'd0);
    check("init_busy[2] after sweep", 32'(busy[2]), 32'd0);

    // The sweep leaves every location zero
    for (int i = 0; i < AD; i++) mdl[i] = 8'h00;
    model_on = 1'b1;

    // Every wide word reads back zero, back-to-back
    for (int b = 0; b < BD; b++) drive(0, 0, '0, '0, 1, 0, 9'(b), '0);
    idle(2);

    // Narrow writes assembled into one wide word
    drive(1, 1, 10'd0, 8'h11, 0, 0, '0, '0);
    drive(1, 1, 10'd1, 8'h22, 0, 0, '0, '0);
    drive(0, 0, '0, '0, 1, 0, 9'd0, '0);
    idle(2);

    // Wide write read back as two narrow lanes
    drive(0, 0, '0, '0, 1, 1, 9'd5, 16'hBEEF);
    drive(1, 0, 10'd10, '0, 0, 0, '0, '0);
    drive(1, 0, 10'd11, '0, 0, 0, '0, '0);
    idle(2);

    // Double write to the same word: A lane wins, collision flagged
    drive(1, 1, 10'd10, 8'hAA, 1, 1, 9'd5, 16'h1234);
    drive(0, 0, '0, '0, 1, 0, 9'd5, '0);
    idle(2);

    // Same-port read-during-write per write mode
    drive(1, 1, 10'd20, 8'h33, 0, 0, '0, '0);
    drive(1, 1, 10'd20, 8'h55, 0, 0, '0, '0);
    drive(1, 0, 10'd20, '0, 0, 0, '0, '0);
    idle(2);

    // Randomised traffic concentrated on a few words to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      logic [9:0] ra;
      logic [8:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? 9'($urandom)  : 9'($urandom_range(0, 7));
      drive(1'($urandom), 1'($urandom), ra, 8'($urandom),
            1'($urandom), 1'($urandom), rb, 16'($urandom));
    end
    idle(5);

    for (int m = 0; m < NI; m++) begin
      check($sformatf("port A results left[%0d]", m), 32'(qa[m].size()), 32'd0);
      check($sformatf("port B results left[%0d]", m), 32'(qb[m].size()), 32'd0);
    end
    check("collisions left", 32'(coll_due.size()), 32'd0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
